// File: rtl/scaler_v_sched.sv
// Vertical cubic scaler line scheduler.
// Tracks received input lines and issues one request per output line.
module scaler_v_sched #(
    parameter int LINE_STEP      = 128,
    parameter int COE_WIDTH      = 8,
    parameter int LINE_CNT_WIDTH = 12,
    parameter int STEP_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STEP_WIDTH-1:0]     scale_step,
    input  logic                      vs_i,
    input  logic                      hs_i,
    input  logic                      eof_i,
    output logic                      req_o,
    input  logic                      ack_i,
    output logic [LINE_CNT_WIDTH-1:0] line_sel_o,
    output logic [COE_WIDTH-1:0]      coe_o,
    output logic [LINE_CNT_WIDTH-1:0] out_cnt_o,
    output logic                      frame_done_o,
    output logic                      busy_o
);

    localparam int LS_W = $clog2(LINE_STEP);
    localparam int PW   = LINE_CNT_WIDTH + LS_W;
    localparam int SW   = ((PW > STEP_WIDTH) ? PW : STEP_WIDTH) + 1;
    localparam int CW   = LINE_CNT_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             pos_q, pos_d;
    logic [LINE_CNT_WIDTH-1:0] rcvd_q, rcvd_d;
    logic [LINE_CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
    logic                      eof_q, eof_d;
    logic                      ovf_q, ovf_d;
    logic [STEP_WIDTH-1:0]     step_q, step_d;
    logic                      done_q, done_d;

    logic [LINE_CNT_WIDTH-1:0] base;
    logic [CW-1:0]             base_x;
    logic [CW-1:0]             rcvd_x;
    logic                      have_taps;
    logic                      can_flush;
    logic [SW-1:0]             sum;
    logic                      sum_ovf;

    assign base      = pos_q[PW-1:LS_W];
    assign base_x    = CW'(base);
    assign rcvd_x    = CW'(rcvd_q);
    assign have_taps = (base_x + CW'(3)) <= rcvd_x;
    assign can_flush = eof_q && (base_x < rcvd_x);
    assign sum       = SW'(pos_q) + SW'(step_q);
    assign sum_ovf   = |sum[SW-1:PW];

    assign req_o        = (state_q == ISSUE);
    assign busy_o       = (state_q != IDLE);
    assign line_sel_o   = base;
    assign coe_o        = COE_WIDTH'(pos_q[LS_W-1:0]) << (COE_WIDTH - LS_W);
    assign out_cnt_o    = out_cnt_q;
    assign frame_done_o = done_q;

    // Next-state: line counting, eof capture, handshake, vs restart
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        rcvd_d    = rcvd_q;
        out_cnt_d = out_cnt_q;
        eof_d     = eof_q;
        ovf_d     = ovf_q;
        step_d    = step_q;
        done_d    = 1'b0;

        if (state_q != IDLE) begin
            if (hs_i && !(&rcvd_q)) begin
                rcvd_d = rcvd_q + 1'b1;
            end
            if (eof_i) begin
                eof_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            WAIT: begin
                if (ovf_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (have_taps || can_flush) begin
                    state_d = ISSUE;
                end else if (eof_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (ack_i) begin
                    if (sum_ovf) begin
                        ovf_d = 1'b1;
                    end else begin
                        pos_d = sum[PW-1:0];
                    end
                    out_cnt_d = out_cnt_q + 1'b1;
                    state_d   = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (vs_i) begin
            state_d   = WAIT;
            pos_d     = '0;
            rcvd_d    = '0;
            out_cnt_d = '0;
            eof_d     = 1'b0;
            ovf_d     = 1'b0;
            done_d    = 1'b0;
            if (scale_step == '0) begin
                step_d = STEP_WIDTH'(LINE_STEP);
            end else begin
                step_d = scale_step;
            end
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pos_q     <= '0;
            rcvd_q    <= '0;
            out_cnt_q <= '0;
            eof_q     <= 1'b0;
            ovf_q     <= 1'b0;
            step_q    <= STEP_WIDTH'(LINE_STEP);
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            rcvd_q    <= rcvd_d;
            out_cnt_q <= out_cnt_d;
            eof_q     <= eof_d;
            ovf_q     <= ovf_d;
            step_q    <= step_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_scaler_v_sched.sv
// Directed bench for scaler_v_sched.
// Auto-responder acks one cycle after req; monitor logs handshakes.
module tb_scaler_v_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] scale_step = '0;
    logic        vs_i = 1'b0;
    logic        hs_i = 1'b0;
    logic        eof_i = 1'b0;
    logic        req_o;
    logic        ack_i = 1'b0;
    logic [11:0] line_sel_o;
    logic [7:0]  coe_o;
    logic [11:0] out_cnt_o;
    logic        frame_done_o;
    logic        busy_o;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int n_log = 0;
    logic auto_ack = 1'b0;
    logic eof_sent = 1'b0;
    logic [11:0] log_sel [64];
    logic [7:0]  log_coe [64];
    logic [11:0] log_cnt [64];
    logic        log_eof [64];

    scaler_v_sched dut (
        .clk          (clk),
        .rst          (rst),
        .scale_step   (scale_step),
        .vs_i         (vs_i),
        .hs_i         (hs_i),
        .eof_i        (eof_i),
        .req_o        (req_o),
        .ack_i        (ack_i),
        .line_sel_o   (line_sel_o),
        .coe_o        (coe_o),
        .out_cnt_o    (out_cnt_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (req_o && ack_i && n_log < 64) begin
            log_sel[n_log] = line_sel_o;
            log_coe[n_log] = coe_o;
            log_cnt[n_log] = out_cnt_o;
            log_eof[n_log] = eof_sent;
            n_log++;
        end
        if (frame_done_o) done_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (auto_ack && req_o && !ack_i) ack_i = 1'b1;
        else ack_i = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_log();
        n_log = 0;
        eof_sent = 1'b0;
        for (int i = 0; i < 64; i++) begin
            log_sel[i] = 'x;
            log_coe[i] = 'x;
            log_cnt[i] = 'x;
            log_eof[i] = 1'bx;
        end
    endtask

    task automatic pulse_vs(input logic [15:0] s);
        scale_step = s;
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
    endtask

    task automatic pulse_hs();
        hs_i = 1'b1;
        tick();
        hs_i = 1'b0;
    endtask

    task automatic pulse_eof();
        eof_i = 1'b1;
        eof_sent = 1'b1;
        tick();
        eof_i = 1'b0;
    endtask

    task automatic wait_done(input int start, input string nm);
        for (int k = 0; k < 400 && done_cnt == start; k++) tick();
        total++;
        if (done_cnt == start) begin
            bad++;
            $display("FAIL %s_done_timeout: got no frame_done want 1", nm);
        end
    endtask

    task automatic wait_req(input string nm);
        for (int k = 0; k < 200 && !req_o; k++) tick();
        total++;
        if (req_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_req_timeout: got %b want 1", nm, req_o);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (req_o !== 1'b0) begin
            bad++; $display("FAIL rst_req: got %b want 0", req_o);
        end
        total++;
        if (line_sel_o !== 12'd0) begin
            bad++; $display("FAIL rst_sel: got %0d want 0", line_sel_o);
        end
        total++;
        if (coe_o !== 8'd0) begin
            bad++; $display("FAIL rst_coe: got %0d want 0", coe_o);
        end
        total++;
        if (out_cnt_o !== 12'd0) begin
            bad++; $display("FAIL rst_cnt: got %0d want 0", out_cnt_o);
        end
        total++;
        if ({frame_done_o, busy_o} !== 2'b00) begin
            bad++; $display("FAIL rst_done_busy: got %b want 00", {frame_done_o, busy_o});
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_downscale();
        int d0;
        clear_log();
        auto_ack = 1'b1;
        d0 = done_cnt;
        pulse_vs(16'd256);
        for (int i = 0; i < 8; i++) begin
            pulse_hs();
            idle(3);
        end
        pulse_eof();
        wait_done(d0, "down");
        idle(5);
        total++;
        if (n_log != 4) begin
            bad++; $display("FAIL down_nreq: got %0d want 4", n_log);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_sel[i] !== 12'(2 * i) || log_coe[i] !== 8'd0 || log_cnt[i] !== 12'(i)) begin
                bad++;
                $display("FAIL down_req[%0d]: got sel=%0d coe=%0d cnt=%0d want sel=%0d coe=0 cnt=%0d",
                         i, log_sel[i], log_coe[i], log_cnt[i], 2 * i, i);
            end
        end
        total++;
        if (log_eof[2] !== 1'b0 || log_eof[3] !== 1'b1) begin
            bad++; $display("FAIL down_eof_order: got %b%b want 01", log_eof[2], log_eof[3]);
        end
        total++;
        if (done_cnt - d0 != 1 || busy_o !== 1'b0) begin
            bad++; $display("FAIL down_done: got done=%0d busy=%b want 1 0", done_cnt - d0, busy_o);
        end
    endtask

    task automatic test_upscale();
        int d0;
        logic [7:0] ec;
        clear_log();
        auto_ack = 1'b1;
        d0 = done_cnt;
        pulse_vs(16'd64);
        pulse_hs();
        idle(2);
        pulse_hs();
        idle(2);
        pulse_hs();
        total++;
        if (req_o !== 1'b0) begin
            bad++; $display("FAIL up_lat_early: got %b want 0", req_o);
        end
        tick();
        total++;
        if (req_o !== 1'b1) begin
            bad++; $display("FAIL up_lat: got %b want 1", req_o);
        end
        idle(10);
        total++;
        if (n_log != 2) begin
            bad++; $display("FAIL up_nreq_3lines: got %0d want 2", n_log);
        end
        pulse_hs();
        idle(10);
        pulse_eof();
        wait_done(d0, "up");
        total++;
        if (n_log != 8) begin
            bad++; $display("FAIL up_nreq: got %0d want 8", n_log);
        end
        for (int i = 0; i < 8; i++) begin
            ec = (i % 2 == 1) ? 8'd128 : 8'd0;
            total++;
            if (log_sel[i] !== 12'(i / 2) || log_coe[i] !== ec) begin
                bad++;
                $display("FAIL up_req[%0d]: got sel=%0d coe=%0d want sel=%0d coe=%0d",
                         i, log_sel[i], log_coe[i], i / 2, ec);
            end
        end
    endtask

    task automatic test_fractional();
        int d0;
        logic [11:0] es [4];
        logic [7:0]  ec [4];
        es[0] = 12'd0; es[1] = 12'd1; es[2] = 12'd3; es[3] = 12'd4;
        ec[0] = 8'd0; ec[1] = 8'd128; ec[2] = 8'd0; ec[3] = 8'd128;
        clear_log();
        auto_ack = 1'b1;
        d0 = done_cnt;
        pulse_vs(16'd192);
        for (int i = 0; i < 6; i++) begin
            pulse_hs();
            idle(2);
        end
        pulse_eof();
        wait_done(d0, "frac");
        total++;
        if (n_log != 4) begin
            bad++; $display("FAIL frac_nreq: got %0d want 4", n_log);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_sel[i] !== es[i] || log_coe[i] !== ec[i]) begin
                bad++;
                $display("FAIL frac_req[%0d]: got sel=%0d coe=%0d want sel=%0d coe=%0d",
                         i, log_sel[i], log_coe[i], es[i], ec[i]);
            end
        end
        total++;
        if (line_sel_o !== 12'd6) begin
            bad++; $display("FAIL frac_endpos: got %0d want 6", line_sel_o);
        end
    endtask

    task automatic test_ack_stall();
        int d0;
        logic stable;
        logic [11:0] cs;
        logic [7:0] cc;
        clear_log();
        auto_ack = 1'b0;
        d0 = done_cnt;
        pulse_vs(16'd128);
        for (int i = 0; i < 3; i++) begin
            pulse_hs();
            idle(1);
        end
        wait_req("stall");
        cs = line_sel_o;
        cc = coe_o;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            hs_i = (c == 3 || c == 9 || c == 15);
            tick();
            if (req_o !== 1'b1 || line_sel_o !== cs || coe_o !== cc) stable = 1'b0;
        end
        hs_i = 1'b0;
        total++;
        if (stable !== 1'b1 || cs !== 12'd0) begin
            bad++; $display("FAIL stall_hold: got stable=%b sel=%0d want 1 0", stable, cs);
        end
        auto_ack = 1'b1;
        pulse_eof();
        wait_done(d0, "stall");
        total++;
        if (n_log != 6) begin
            bad++; $display("FAIL stall_nreq: got %0d want 6", n_log);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (log_sel[i] !== 12'(i)) begin
                bad++; $display("FAIL stall_sel[%0d]: got %0d want %0d", i, log_sel[i], i);
            end
        end
    endtask

    task automatic test_abort();
        int d0;
        auto_ack = 1'b0;
        d0 = done_cnt;
        clear_log();
        pulse_vs(16'd128);
        for (int i = 0; i < 3; i++) begin
            pulse_hs();
            idle(1);
        end
        wait_req("abort");
        pulse_vs(16'd0);
        total++;
        if (req_o !== 1'b0 || busy_o !== 1'b1 || out_cnt_o !== 12'd0) begin
            bad++;
            $display("FAIL abort_drop: got req=%b busy=%b cnt=%0d want 0 1 0", req_o, busy_o, out_cnt_o);
        end
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse_hs();
            idle(1);
        end
        pulse_eof();
        wait_done(d0, "abort");
        idle(5);
        total++;
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL abort_done: got %0d want 1", done_cnt - d0);
        end
        total++;
        if (n_log != 4) begin
            bad++; $display("FAIL abort_nreq: got %0d want 4", n_log);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_sel[i] !== 12'(i) || log_coe[i] !== 8'd0) begin
                bad++;
                $display("FAIL abort_req[%0d]: got sel=%0d coe=%0d want sel=%0d coe=0",
                         i, log_sel[i], log_coe[i], i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        clear_log();
        auto_ack = 1'b1;
        pulse_vs(16'd64);
        for (int i = 0; i < 4; i++) begin
            pulse_hs();
            idle(1);
        end
        idle(20);
        auto_ack = 1'b0;
        pulse_hs();
        wait_req("rmid");
        total++;
        if (line_sel_o !== 12'd2 || out_cnt_o !== 12'd4) begin
            bad++; $display("FAIL rmid_pre: got sel=%0d cnt=%0d want 2 4", line_sel_o, out_cnt_o);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (req_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL rmid_req_busy: got %b%b want 00", req_o, busy_o);
        end
        total++;
        if (line_sel_o !== 12'd0 || coe_o !== 8'd0 || out_cnt_o !== 12'd0 || frame_done_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_outs: got sel=%0d coe=%0d cnt=%0d done=%b want 0 0 0 0",
                     line_sel_o, coe_o, out_cnt_o, frame_done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        clear_log();
        auto_ack = 1'b1;
        d0 = done_cnt;
        pulse_vs(16'd128);
        for (int i = 0; i < 4; i++) begin
            pulse_hs();
            idle(1);
        end
        pulse_eof();
        wait_done(d0, "rmid");
        total++;
        if (n_log != 4) begin
            bad++; $display("FAIL rmid_nreq: got %0d want 4", n_log);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_sel[i] !== 12'(i) || log_coe[i] !== 8'd0) begin
                bad++;
                $display("FAIL rmid_req[%0d]: got sel=%0d coe=%0d want sel=%0d coe=0",
                         i, log_sel[i], log_coe[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_downscale();
        test_upscale();
        test_fractional();
        test_ack_stall();
        test_abort();
        test_reset_mid();
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
